router_idata_rx: RTL and testbench
==================================

# router_idata_rx

Receive-side endpoint of the router output-data link: captures flits driven by the upstream registered ODATA flip-flop stage, buffers them in a small FIFO, and presents them to the router core with a valid/ready handshake. Flow control toward the transmitter is credit-based. After reset the block advertises its buffer depth as credits, then returns one credit per flit consumed. It sits in the router wrap slice between the fabric input pins and the router core input port.

## Interface
Parameters:
- `DATA_W`, default 32: flit width in bits.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `OCC_W`, default $clog2(DEPTH+1): occupancy counter width.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion clears state immediately; deassertion is sampled on `clk`.
- `idata_valid`  in  1  flit present on `idata` this cycle (credit protocol, no ready).
- `idata`  in  DATA_W  incoming flit.
- `idata_parity`  in  1  even-parity bit for `idata`. Exists only with `ROUTER_IDATA_PARITY_EN`.
- `credit_ret`  out  1  one-cycle pulse = one credit returned to transmitter.
- `odata_valid`  out  1  head flit valid toward router core.
- `odata`  out  DATA_W  head flit.
- `odata_ready`  in  1  core accepts head flit.
- `occupancy`  out  OCC_W  flits currently stored.
- `overflow_err`  out  1  sticky; a flit arrived with no free entry.
- `parity_err`  out  1  sticky parity mismatch. Exists only with `ROUTER_IDATA_PARITY_EN`.

## Operation
- FSM states: INIT, RUN.
  - Reset enters INIT.
  - INIT asserts `credit_ret` for exactly DEPTH consecutive cycles, starting on the first clock after reset deassertion. A down-counter tracks the pulses.
  - When the counter reaches zero, INIT moves to RUN. RUN is held until the next reset.
- Push:
  - Condition: `idata_valid`=1, and either occupancy<DEPTH or a pop occurs in the same cycle.
  - Pushes are accepted in both INIT and RUN.
  - If `idata_valid`=1 while occupancy==DEPTH and no pop occurs, the flit is dropped, occupancy is unchanged and `overflow_err` is set.
- Pop: `odata_valid` && `odata_ready`.
- Simultaneous push and pop: occupancy unchanged, both flits handled correctly. This includes the full and the one-entry cases.
- Credits in RUN: `credit_ret` is the registered pop strobe, so each pop produces exactly one pulse.
- Credits in INIT: a pop during INIT must not lose its credit. It is deferred and emitted on the first RUN cycle; a pending-credit counter of width OCC_W holds it. In normal operation INIT pops cannot occur before credits exist, but the case must be handled.
- `odata`/`odata_valid` come directly from the FIFO head register (first-word-fall-through). `odata` is held stable while `odata_valid`=1 and `odata_ready`=0.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from occupancy.
- Error flags are sticky until reset.

## Timing
- Reset values:
  - `odata_valid`=0, `odata`=0, `credit_ret`=0, `occupancy`=0.
  - `overflow_err`=0, `parity_err`=0.
  - FSM=INIT, pointers=0.
- Push-to-output latency: a flit pushed at edge N has `odata_valid`=1 after edge N (visible in cycle N+1) when the FIFO was empty.
- Pop-to-credit latency: a pop at edge N gives `credit_ret`=1 in cycle N+1, for one cycle.
- Occupancy updates on the same edge as the push or pop.
- Reset asserted mid-operation:
  - All stored flits are discarded.
  - Outputs go to reset values asynchronously.
  - The INIT credit sequence restarts after deassertion.

## Configuration
- Macro `ROUTER_IDATA_PARITY_EN`.
- Defined:
  - Ports `idata_parity` and `parity_err` exist.
  - On each accepted push, ^{idata,idata_parity}≠0 sets `parity_err`.
  - The flit is still stored.
- Undefined: both ports and all parity logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package `router_wrap_pkg`:
  - `rx_state_e` (INIT, RUN).
  - Default DATA_W/DEPTH localparams.
  - Parity helper function.
- One natural sub-module, `router_idata_fifo`: storage, pointers, occupancy and simultaneous push/pop. The FSM, credit logic and error flags stay in the top module.

## Test plan
- Reset release with DEPTH=4 → `credit_ret` high cycles 1–4 after deassertion, then low; FSM in RUN.
- Push 0xA5A5_0001..0004 with `odata_ready`=0 → occupancy=4, `odata`=0xA5A5_0001 held stable.
- FIFO full, push 0xDEAD_BEEF with no pop → flit dropped, `overflow_err`=1, occupancy stays 4.
- FIFO full, push and pop in the same cycle → occupancy 4, `overflow_err`=0, order preserved, one `credit_ret` pulse next cycle.
- Stream 16 flits with `odata_ready`=1 → output order matches input, 16 `credit_ret` pulses, pointer wrap exercised, each pulse exactly one cycle after its pop.
- With `ROUTER_IDATA_PARITY_EN`, `idata`=0x0000_0001 and `idata_parity`=0 → `parity_err`=1 and the flit is delivered. Reset mid-stream (occupancy=3) → occupancy 0 immediately, INIT credit burst repeats.

Source files
------------

// File: rtl/router_wrap_pkg.sv
// rtl/router_wrap_pkg.sv - shared receive-link types, default sizes and parity helper
package router_wrap_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rx_state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 4;
    localparam int PARITY_MAX_W = 256;

    // Flit plus even-parity bit must have even weight; zero-extending the flit does not change that.
    function automatic logic parity_bad(input logic [PARITY_MAX_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/router_idata_fifo.sv
// rtl/router_idata_fifo.sv - first-word-fall-through flit buffer with occupancy tracking
module router_idata_fifo
    import router_wrap_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              valid_o,
    output logic              full_o,
    output logic [OCC_W-1:0]  occ_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    // A push into a full buffer only happens alongside a pop, so overwriting the head slot is safe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            occ_q <= occ_d;
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (occ_q != '0);
    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign occ_o   = occ_q;

endmodule

// File: rtl/router_idata_rx.sv
// rtl/router_idata_rx.sv - credit-based receive endpoint of the router data link; parity option ROUTER_IDATA_PARITY_EN
module router_idata_rx
    import router_wrap_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idata_valid,
    input  logic [DATA_W-1:0] idata,
`ifdef ROUTER_IDATA_PARITY_EN
    input  logic              idata_parity,
`endif
    output logic              credit_ret,
    output logic              odata_valid,
    output logic [DATA_W-1:0] odata,
    input  logic              odata_ready,
    output logic [OCC_W-1:0]  occupancy,
    output logic              overflow_err
`ifdef ROUTER_IDATA_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    rx_state_e        state_q;
    rx_state_e        state_d;
    logic [OCC_W-1:0] init_cnt_q;
    logic [OCC_W-1:0] init_cnt_d;
    logic [OCC_W-1:0] pend_q;
    logic [OCC_W-1:0] pend_d;
    logic             credit_q;
    logic             credit_d;
    logic             overflow_q;
    logic             push;
    logic             pop;
    logic             full;

    assign pop  = odata_valid && odata_ready;
    assign push = idata_valid && (!full || pop);

    router_idata_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .OCC_W  (OCC_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (idata),
        .rdata_o (odata),
        .valid_o (odata_valid),
        .full_o  (full),
        .occ_o   (occupancy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            init_cnt_q <= OCC_W'(DEPTH);
            pend_q     <= '0;
            credit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pend_q     <= pend_d;
            credit_q   <= credit_d;
        end
    end

    // INIT advertises the whole buffer; pops seen meanwhile are banked and paid out once RUN has no pop of its own.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        pend_d     = pend_q;
        credit_d   = 1'b0;
        case (state_q)
            INIT: begin
                credit_d   = 1'b1;
                init_cnt_d = init_cnt_q - 1'b1;
                if (init_cnt_q == OCC_W'(1)) begin
                    state_d = RUN;
                end
                if (pop) begin
                    pend_d = pend_q + 1'b1;
                end
            end
            RUN: begin
                if (pop) begin
                    credit_d = 1'b1;
                end else if (pend_q != '0) begin
                    credit_d = 1'b1;
                    pend_d   = pend_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (idata_valid && !push) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef ROUTER_IDATA_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (push && parity_bad(PARITY_MAX_W'(idata), idata_parity)) begin
            parity_q <= 1'b1;
        end
    end

    assign parity_err = parity_q;
`endif

    assign credit_ret   = credit_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_router_idata_rx.sv
// tb/tb_router_idata_rx.sv - directed plus randomized self-checking bench for router_idata_rx
module tb_router_idata_rx;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              idata_valid = 1'b0;
    logic [DATA_W-1:0] idata = '0;
    logic              odata_ready = 1'b0;
    logic              credit_ret;
    logic              odata_valid;
    logic [DATA_W-1:0] odata;
    logic [OCC_W-1:0]  occupancy;
    logic              overflow_err;
`ifdef ROUTER_IDATA_PARITY_EN
    logic              idata_parity = 1'b0;
    logic              parity_err;
    logic              par_flip = 1'b0;
    logic              exp_par;
`endif

    logic [DATA_W-1:0] q[$];
    logic              exp_credit;
    logic              exp_ovf;
    int                cyc;
    int                pend;
    int                checks;
    int                errors;

    router_idata_rx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .OCC_W  (OCC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .idata_valid  (idata_valid),
        .idata        (idata),
`ifdef ROUTER_IDATA_PARITY_EN
        .idata_parity (idata_parity),
`endif
        .credit_ret   (credit_ret),
        .odata_valid  (odata_valid),
        .odata        (odata),
        .odata_ready  (odata_ready),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
`ifdef ROUTER_IDATA_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r);
        logic popf;
        logic pushf;
        idata_valid = v;
        idata       = d;
        odata_ready = r;
`ifdef ROUTER_IDATA_PARITY_EN
        idata_parity = (^d) ^ par_flip;
`endif
        #1;
        chk("credit_ret", credit_ret, exp_credit);
        chk("occupancy", occupancy, q.size());
        chk("odata_valid", odata_valid, q.size() != 0);
        if (q.size() != 0) chk("odata", odata, q[0]);
        chk("overflow_err", overflow_err, exp_ovf);
`ifdef ROUTER_IDATA_PARITY_EN
        chk("parity_err", parity_err, exp_par);
`endif
        popf  = r && (q.size() != 0);
        pushf = v && ((q.size() < DEPTH) || popf);
        if (v && !pushf) exp_ovf = 1'b1;
`ifdef ROUTER_IDATA_PARITY_EN
        if (pushf && par_flip) exp_par = 1'b1;
`endif
        if (popf) void'(q.pop_front());
        if (pushf) q.push_back(d);
        if (cyc + 1 <= DEPTH) exp_credit = 1'b1;
        else if (popf) exp_credit = 1'b1;
        else if (pend > 0) begin
            exp_credit = 1'b1;
            pend--;
        end else exp_credit = 1'b0;
        if (popf && cyc < DEPTH) pend++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        idata_valid = 1'b0;
        odata_ready = 1'b0;
        #1;
        chk("rst_occupancy", occupancy, 0);
        chk("rst_odata_valid", odata_valid, 0);
        chk("rst_odata", odata, 0);
        chk("rst_credit_ret", credit_ret, 0);
        chk("rst_overflow_err", overflow_err, 0);
`ifdef ROUTER_IDATA_PARITY_EN
        chk("rst_parity_err", parity_err, 0);
        exp_par = 1'b0;
`endif
        q.delete();
        exp_credit = 1'b0;
        exp_ovf    = 1'b0;
        pend       = 0;
        cyc        = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        #2;
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'hA5A5_0000 + DATA_W'(i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        chk("full_head_held", odata, 32'hA5A5_0001);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("drop_overflow", overflow_err, 1);
        chk("drop_occupancy", occupancy, 4);

        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hB000_0000 + DATA_W'(i), 1'b0);
        cycle(1'b1, 32'hC0DE_0005, 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk("full_pushpop_credit_gone", credit_ret, 0);
        chk("full_pushpop_no_ovf", overflow_err, 0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h5000_0000 + DATA_W'(i), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 2) != 0), DATA_W'($urandom), 1'($urandom_range(0, 2) == 0));

        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h7700_0000 + DATA_W'(i), 1'b0);
        chk("pre_reset_occupancy", occupancy, 3);
        do_reset();
        cycle(1'b1, 32'h1234_5678, 1'b0);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0);

`ifdef ROUTER_IDATA_PARITY_EN
        par_flip = 1'b1;
        cycle(1'b1, 32'h0000_0001, 1'b0);
        par_flip = 1'b0;
        cycle(1'b0, '0, 1'b1);
        chk("parity_sticky", parity_err, 1);
        cycle(1'b0, '0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
